// File: rtl/ddr_burst_arbiter.sv
// Shares one DDR burst-engine port among NUM_CH channels, each with a write and a read requestor.
// Grant is locked for a whole burst; zero-length bursts finish locally without touching the engine.
module ddr_burst_arbiter #(
    parameter int NUM_CH     = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 25,
    parameter int ARB_MODE   = 0
) (
    input  logic                           mem_clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              ch_wr_burst_req,
    input  logic [NUM_CH*10-1:0]           ch_wr_burst_len,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   ch_wr_burst_addr,
    output logic [NUM_CH-1:0]              ch_wr_burst_data_req,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_wr_burst_data,
    output logic [NUM_CH-1:0]              ch_wr_burst_finish,
    input  logic [NUM_CH-1:0]              ch_rd_burst_req,
    input  logic [NUM_CH*10-1:0]           ch_rd_burst_len,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   ch_rd_burst_addr,
    output logic [NUM_CH-1:0]              ch_rd_burst_data_valid,
    output logic [DATA_WIDTH-1:0]          ch_rd_burst_data,
    output logic [NUM_CH-1:0]              ch_rd_burst_finish,
    output logic                           m_wr_burst_req,
    output logic [9:0]                     m_wr_burst_len,
    output logic [ADDR_WIDTH-1:0]          m_wr_burst_addr,
    output logic [DATA_WIDTH-1:0]          m_wr_burst_data,
    input  logic                           m_wr_burst_data_req,
    input  logic                           m_wr_burst_finish,
    output logic                           m_rd_burst_req,
    output logic [9:0]                     m_rd_burst_len,
    output logic [ADDR_WIDTH-1:0]          m_rd_burst_addr,
    input  logic                           m_rd_burst_data_valid,
    input  logic                           m_rd_burst_finish,
    input  logic [DATA_WIDTH-1:0]          m_rd_burst_data,
    output logic [3:0]                     grant_id,
    output logic                           busy,
    output logic [1:0]                     o_dbg_state
);

    localparam int NREQ = 2 * NUM_CH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_BUSY = 2'd1,
        RD_BUSY = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                r_state, w_next;
    logic [3:0]            r_grant, r_ptr, w_win, w_idx;
    logic [9:0]            r_len, w_win_len;
    logic [ADDR_WIDTH-1:0] r_addr, w_win_addr;
    logic                  r_zero, w_found;
    logic [15:0]           w_req;

    // Requestor k = 2*ch + is_read, so grant_id bit 0 is the read flag.
    always_comb begin
        w_req = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_req[2*i]   = ch_wr_burst_req[i];
            w_req[2*i+1] = ch_rd_burst_req[i];
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        if (ARB_MODE == 0) begin
            for (int off = 0; off < NREQ; off++) begin
                w_idx = 4'((int'(r_ptr) + off) % NREQ);
                if (!w_found && w_req[w_idx]) begin
                    w_found = 1'b1;
                    w_win   = w_idx;
                end
            end
        end else begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (w_req[k]) begin
                    w_found = 1'b1;
                    w_win   = 4'(k);
                end
            end
        end
    end

    always_comb begin
        w_win_len  = '0;
        w_win_addr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_win == 4'(2*i)) begin
                w_win_len  = ch_wr_burst_len[10*i +: 10];
                w_win_addr = ch_wr_burst_addr[ADDR_WIDTH*i +: ADDR_WIDTH];
            end
            if (w_win == 4'(2*i+1)) begin
                w_win_len  = ch_rd_burst_len[10*i +: 10];
                w_win_addr = ch_rd_burst_addr[ADDR_WIDTH*i +: ADDR_WIDTH];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    if (w_win_len == 10'd0) w_next = DONE;
                    else if (w_win[0])      w_next = RD_BUSY;
                    else                    w_next = WR_BUSY;
                end
            end
            WR_BUSY: if (m_wr_burst_finish) w_next = DONE;
            RD_BUSY: if (m_rd_burst_finish) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_len   <= '0;
            r_addr  <= '0;
            r_zero  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_found) begin
                r_grant <= w_win;
                r_len   <= w_win_len;
                r_addr  <= w_win_addr;
                r_zero  <= (w_win_len == 10'd0);
                r_ptr   <= (w_win == 4'(NREQ - 1)) ? 4'd0 : w_win + 4'd1;
            end
        end
    end

    assign m_wr_burst_req   = (r_state == WR_BUSY);
    assign m_rd_burst_req   = (r_state == RD_BUSY);
    assign m_wr_burst_len   = m_wr_burst_req ? r_len  : '0;
    assign m_wr_burst_addr  = m_wr_burst_req ? r_addr : '0;
    assign m_rd_burst_len   = m_rd_burst_req ? r_len  : '0;
    assign m_rd_burst_addr  = m_rd_burst_req ? r_addr : '0;
    assign busy             = m_wr_burst_req || m_rd_burst_req;
    assign grant_id         = r_grant;
    assign ch_rd_burst_data = m_rd_burst_data;
    assign o_dbg_state      = r_state;

    // Engine strobes reach only the granted requestor; a zero-length grant finishes in DONE.
    always_comb begin
        m_wr_burst_data        = '0;
        ch_wr_burst_data_req   = '0;
        ch_wr_burst_finish     = '0;
        ch_rd_burst_data_valid = '0;
        ch_rd_burst_finish     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_grant == 4'(2*i)) begin
                m_wr_burst_data         = ch_wr_burst_data[DATA_WIDTH*i +: DATA_WIDTH];
                ch_wr_burst_data_req[i] = m_wr_burst_req && m_wr_burst_data_req;
                ch_wr_burst_finish[i]   = (m_wr_burst_req && m_wr_burst_finish) ||
                                          (r_state == DONE && r_zero);
            end
            if (r_grant == 4'(2*i+1)) begin
                ch_rd_burst_data_valid[i] = m_rd_burst_req && m_rd_burst_data_valid;
                ch_rd_burst_finish[i]     = (m_rd_burst_req && m_rd_burst_finish) ||
                                            (r_state == DONE && r_zero);
            end
        end
    end

endmodule
